ifu_prefetch: RTL
=================

Name: ifu_prefetch

Overview:
- Instruction prefetch unit sitting directly upstream of the instruction ROM.
- Generates sequential word addresses into the ROM's synchronous-read port (data returns 1 cycle after address).
- Buffers returned instructions in a small FIFO and presents them to the core's decode stage over a valid/ready handshake.
- Handles jump/branch redirects by flushing buffered and in-flight fetches.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rom_addr_o  output  32  byte address driven to ROM; ROM indexes with bits [27:2]
- rom_req_o  output  1  address on rom_addr_o is a real fetch; response is expected next cycle
- rom_data_i  input  32  ROM read data, valid the cycle after rom_req_o
- jump_i  input  1  redirect request from execute stage
- jump_addr_i  input  32  redirect target; bits [1:0] ignored
- inst_o  output  32  instruction at FIFO head
- inst_addr_o  output  32  byte address of inst_o
- inst_valid_o  output  1  FIFO head valid
- inst_ready_i  input  1  decode accepts head this cycle

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - pc = RESET_PC
  - inflight = 0
  - FIFO empty, so inst_valid_o = 0
  - inst_o = INST_NOP (32'h0000_0013), inst_addr_o = 0
  - rom_req_o = 0 while rst_n low
- Issue rule:
  - rom_req_o = 1 when (count + inflight) < DEPTH, or when jump_i = 1.
  - rom_addr_o = jump_i ? {jump_addr_i[31:2],2'b00} : pc.
  - On issue, pc <= rom_addr_o + 4 and inflight <= 1, tagged with the issued address.
  - With no issue, inflight <= 0.
  - Conservative credit: a same-cycle pop does not free a slot until the next cycle.
- Return:
  - If inflight = 1 and the response is not killed, push {rom_data_i, tagged address} into the FIFO at the clock edge.
  - The credit rule guarantees the push never overflows.
- Output:
  - inst_valid_o = (count ≠ 0).
  - inst_o and inst_addr_o come from the FIFO head; inst_o = INST_NOP when empty.
  - Pop when inst_valid_o & inst_ready_i.
  - Head stays stable while valid and not ready.
- Latency:
  - Request at cycle T → data pushed at edge ending T+1 → inst_valid_o high at T+2.
  - Same for the first fetch after reset: first rom_req_o in the first cycle after rst_n rises.
- Redirect (jump_i = 1 in cycle T):
  - FIFO cleared at the edge ending T.
  - Any response arriving in T+1 from a request issued before T is discarded (kill flag).
  - Request at the jump target issues in T itself.
  - The target instruction appears with inst_valid_o at T+2.
  - A pop in cycle T is meaningless; the flush wins.
  - Consecutive jumps: the latest target wins; earlier in-flight responses are discarded.
- Throughput: with inst_ready_i held high, one instruction per cycle after the initial 2-cycle fill.
- Address wrap: pc wraps modulo 2^32, no error.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); an in-flight response is discarded.
- ROM write port: ROM we/sel are driven low/zero by the top-level; this block is read-only.

Decomposition:
- Shared defines package holds:
  - INST_NOP
  - RESET_PC default
  - ZeroWord
  - a packed struct fetch_entry_t {inst[31:0], addr[31:0]}
- One sub-module, prefetch_fifo:
  - synchronous FIFO parameterised on DEPTH and entry width
  - ports: push, pop, flush, full, empty, count
  - flush has priority over push and pop in the same cycle.
- ifu_prefetch itself owns pc, the inflight/kill flags and the issue logic.

Test Plan:
- Reset then run, ready = 1, ROM word n = 32'hA000_0000+n → rom_addr_o 0,4,8,…; inst_valid_o first high 2 cycles after reset release with inst_o = A000_0000, inst_addr_o = 0; then 1 instruction per cycle in order.
- Backpressure: inst_ready_i = 0 for 10 cycles → exactly DEPTH = 4 entries buffered, rom_req_o low once count + inflight = 4, head stable; ready = 1 → drains 0,4,8,C then continues at 0x10 with no gap or duplicate.
- Jump at cycle T to 32'h0000_0102 while FIFO holds 3 entries → rom_addr_o = 0x100 in T, FIFO empty at T+1, stale response dropped; inst_valid_o at T+2 with inst_addr_o = 0x100, followed by 0x104.
- Back-to-back jumps to 0x200 then 0x300 → no instruction from 0x200 or earlier is ever presented; the first valid output is 0x300.
- Jump coinciding with a pop and a FIFO-full condition → flush wins, request issued at the target, no overflow, count = 0 next cycle.
- Assert rst_n low mid-stream with 2 entries buffered → inst_valid_o = 0 and inst_o = INST_NOP immediately (asynchronous); after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: reset constants and
// the FIFO entry layout pairing an instruction with its fetch address.
package ifu_prefetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ZeroWord         = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Small synchronous FIFO holding fetched instructions; flush beats push/pop.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: issues sequential ROM reads, buffers returned words
// and hands them to decode over valid/ready; a jump flushes everything.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr_o,
  output logic        rom_req_o,
  input  logic [31:0] rom_data_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: decode takes the head on any cycle with inst_valid_o and
  // inst_ready_i both high; the head is held stable while valid and not ready.

  logic [31:0]  pc_q;
  logic [31:0]  tag_q;
  logic         inflight_q;
  logic [31:0]  jump_target;
  logic [CW-1:0] occupancy;
  logic         credit_ok;
  logic         issue;
  logic         resp_kill;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t entry_in;
  fetch_entry_t entry_head;

  assign jump_target = jump_addr_i & ~32'h3;

  // Credit counts the current occupancy before any same-cycle pop.
  assign occupancy = fifo_count + CW'(inflight_q);
  assign credit_ok = ~fifo_full & (occupancy < CW'(DEPTH));
  assign issue     = rst_n & (credit_ok | jump_i);

  assign rom_req_o  = issue;
  assign rom_addr_o = jump_i ? jump_target : pc_q;

  // A response returning while a redirect is taken belongs to the old stream.
  assign resp_kill = jump_i;
  assign push      = inflight_q & ~resp_kill;
  assign pop       = inst_valid_o & inst_ready_i & ~jump_i;

  assign entry_in.inst = rom_data_i;
  assign entry_in.addr = tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= ZeroWord;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q  <= rom_addr_o + 32'd4;
        tag_q <= rom_addr_o;
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (entry_in),
    .pop_i   (pop),
    .flush_i (jump_i),
    .dout_o  (entry_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign inst_valid_o = ~fifo_empty;
  assign inst_o       = fifo_empty ? INST_NOP : entry_head.inst;
  assign inst_addr_o  = fifo_empty ? ZeroWord : entry_head.addr;

endmodule
